// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_serial_adder
// Purpose  : Multi-cycle ripple adder, CHUNK bits per clock, start/busy/done.
//            Optional subtract mode under CHUNKED_SERIAL_ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             run_c_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic             w_accept;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;

    // Subtraction is folded into capture: store ~B and force the carry-in,
    // so the RUN datapath is identical in both modes.
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    assign w_b_in = sub ? ~B : B;
    assign w_c_in = sub ? 1'b1 : C;
`else
    assign w_b_in = B;
    assign w_c_in = C;
`endif

    assign w_accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    assign w_b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, run_c_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            run_c_q <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (w_accept) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            a_q     <= A;
            b_q     <= w_b_in;
            run_c_q <= w_c_in;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                    run_c_q                     <= w_chunk_sum[CHUNK];
                    if (idx_q == IW'(NCHUNK - 1)) begin
                        carry_q <= w_chunk_sum[CHUNK];
                        idx_q   <= '0;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign Sum   = sum_q;
    assign Carry = carry_q;

endmodule
`default_nettype wire

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle ripple adder. It is the registered successor to the team's combinational full-adder and 4-bit adder.
- Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, using a start/busy/done handshake.
- Used where a full-width carry chain does not meet timing or area. WIDTH=CHUNK degenerates to a registered single-cycle adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is accepting.
- A  input  WIDTH  operand A; captured on the accepted start.
- B  input  WIDTH  operand B; captured on the accepted start.
- C  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse; Sum and Carry are valid.
- Sum  output  WIDTH  result (A+B+C) mod 2^WIDTH.
- Carry  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: rst=1 at a rising edge forces state=IDLE, busy=0, done=0, Sum=0, Carry=0, chunk index=0, internal operand registers=0. Reset has priority over everything, including start on the same edge.
- States: IDLE, RUN, DONE.
- Accepting condition: state is IDLE or DONE.
- Start accepted (accepting and start=1 at an edge):
  - latch A, B, C;
  - clear the Sum accumulator;
  - set chunk index=0;
  - go to RUN (busy=1, done=0).
- RUN, each edge:
  - compute chunk i = A[i*CHUNK +: CHUNK] + B[same] + running carry;
  - write the low CHUNK bits into Sum[i*CHUNK +: CHUNK];
  - running carry = chunk carry-out;
  - increment i.
- After chunk NCHUNK-1: Carry = final carry, go to DONE (busy=0, done=1).
- DONE: lasts exactly one cycle.
  - If start=1 on that edge, a new operation is accepted (back-to-back) and done falls.
  - Otherwise go to IDLE and done falls.
- Latency: start high in cycle 0 gives busy=1 in cycles 1..NCHUNK and done=1 in cycle NCHUNK+1. Throughput is one result per NCHUNK+1 cycles.
- Sum and Carry:
  - Hold their final values from DONE until the next accepted start.
  - Sum chunks update progressively during RUN and are not valid until done.
  - Carry is cleared on an accepted start.
- start while in RUN: ignored, with no effect on the operation in flight.
- A, B, C changing after acceptance: no effect on the result.
- Wrap-around: the result is modulo 2^WIDTH; the overflow bit appears only on Carry.
- Reset mid-operation (RUN or DONE): the operation is abandoned and all outputs return to reset values on the next edge. No done pulse is issued.

Optional Feature:
- Macro: CHUNKED_SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port `sub` (1 bit), captured on the accepted start.
  - sub=1: the block computes A + ~B + 1 (C is ignored). Carry=1 means no borrow (A>=B unsigned); Carry=0 means a borrow.
  - sub=0: behaviour is identical to the undefined build.
- Undefined: the `sub` port does not exist; the block is add-only.

Test Plan:
- Basic add and latency (WIDTH=8, CHUNK=4): A=0x00, B=0x00, C=0, start in cycle 0 -> busy=1 in cycles 1-2, done=1 in cycle 3 only, Sum=0x00, Carry=0.
- Inter-chunk carry: A=0x0F, B=0x01, C=0 -> Sum=0x10, Carry=0.
- Full wrap: A=0xFF, B=0x00, C=1 -> Sum=0x00, Carry=1.
- Protocol:
  - start held high through RUN with new operands -> the first result, 0x5A+0x11 = Sum=0x6B, Carry=0, is unaffected.
  - start in the DONE cycle with A=0x80, B=0x80 -> back-to-back result Sum=0x00, Carry=1, done in cycle 6 (first start in cycle 0, second accepted in cycle 3).
- Reset mid-operation: rst=1 in cycle 1 of an 0xAA+0x55 operation -> in cycle 2 busy=0, done=0, Sum=0, Carry=0, and no done pulse follows.
- Serial mode plus subtract:
  - WIDTH=4, CHUNK=1: sweep all 8 A[0]/B[0]/C combinations with other bits 0 -> Sum[0] and Sum[1] match the full-adder truth table, done in cycle 5.
  - With CHUNKED_SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1, A=0x05, B=0x07 -> Sum=0xFE, Carry=0; A=0x07, B=0x05 -> Sum=0x02, Carry=1.
